// File: rtl/tpuv2.sv
// tpuv2: DIM x DIM signed matrix-multiply engine behind a single-word MMIO port.
//
// Computes C = A*B (CTRL.ACC = 0) or C = C + A*B (CTRL.ACC = 1). A, B and C are
// held internally and are randomly addressable one packed row word at a time.
// The engine is output-stationary: one row i of C is updated per DIM cycles,
// all DIM columns in parallel. A run therefore always takes exactly DIM*DIM cycles.
//
// Optional build macro: SATURATE_EN -- clamp each accumulate step to the signed
// BITS_C range instead of wrapping.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (clears all storage and state)
//   r_w      in   1 = write on this clock edge, 0 = read
//   addr     in   [ADDRW-1:0] byte address
//   dataIn   in   [DATAW-1:0] write data
//   dataOut  out  [DATAW-1:0] read data, combinational from addr
//   busy     out  high while the engine runs
//   done     out  one-cycle pulse during the last compute cycle
//
// Address map (S = DATAW/8 bytes per word):
//   0x0100 A rows, 0x0200 B rows, 0x0300 C rows,
//   0x0400 CTRL, 0x0400+S STATUS {done_sticky, busy}, 0x0400+2S CYCLES.
module tpuv2 #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_w,
    input  logic [ADDRW-1:0] addr,
    input  logic [DATAW-1:0] dataIn,
    output logic [DATAW-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam int S      = DATAW / 8;
    localparam int EPA    = DATAW / BITS_AB;
    localparam int WPA    = (DIM + EPA - 1) / EPA;
    localparam int EPC    = DATAW / BITS_C;
    localparam int WPC    = (DIM + EPC - 1) / EPC;
    localparam int IW     = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CW     = $clog2(DIM * DIM + 1);
    localparam int A_BASE = 'h0100;
    localparam int B_BASE = 'h0200;
    localparam int C_BASE = 'h0300;
    localparam int CTRL_A = 'h0400;
    localparam int STAT_A = 'h0400 + S;
    localparam int CYC_A  = 'h0400 + 2 * S;

    localparam logic [IW-1:0]            LAST  = IW'(DIM - 1);
    localparam logic signed [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
    localparam logic signed [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    // Wrap or clamp a one-bit-wider sum back into the C element width.
    function automatic logic signed [BITS_C-1:0] fit_c(input logic signed [BITS_C:0] s);
        logic signed [BITS_C-1:0] r;
        r = s[BITS_C-1:0];
`ifdef SATURATE_EN
        if (s[BITS_C] != s[BITS_C-1]) r = s[BITS_C] ? C_MIN : C_MAX;
`endif
        return r;
    endfunction

    // One MAC step: base + a*b, product sign-extended/truncated to BITS_C first.
    function automatic logic signed [BITS_C-1:0] mac_step(
        input logic signed [BITS_C-1:0]  base,
        input logic signed [BITS_AB-1:0] a,
        input logic signed [BITS_AB-1:0] b
    );
        logic signed [2*BITS_AB-1:0] prod;
        logic signed [BITS_C-1:0]    pext;
        logic signed [BITS_C:0]      sum;
        prod = a * b;
        pext = BITS_C'(prod);
        sum  = {base[BITS_C-1], base} + {pext[BITS_C-1], pext};
        return fit_c(sum);
    endfunction

    logic signed [BITS_AB-1:0] a_q [DIM][DIM];
    logic signed [BITS_AB-1:0] a_d [DIM][DIM];
    logic signed [BITS_AB-1:0] b_q [DIM][DIM];
    logic signed [BITS_AB-1:0] b_d [DIM][DIM];
    logic signed [BITS_C-1:0]  c_q [DIM][DIM];
    logic signed [BITS_C-1:0]  c_d [DIM][DIM];

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d, k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d, cycles_q, cycles_d;
    logic            acc_q, acc_d, busy_q, busy_d, done_q, done_d, sticky_q, sticky_d;

    // Address decode. Offsets are computed as signed ints so addresses below a
    // base simply miss; misaligned offsets and rows >= DIM also miss.
    int   ua, oa, ob, oc;
    int   a_row, a_wd, b_row, b_wd, c_row, c_wd;
    logic a_hit, b_hit, c_hit, ctrl_hit, stat_hit, cyc_hit;

    always_comb begin
        ua       = int'(addr);
        oa       = ua - A_BASE;
        ob       = ua - B_BASE;
        oc       = ua - C_BASE;
        a_hit    = (oa >= 0) && (oa < DIM * WPA * S) && ((oa % S) == 0);
        b_hit    = (ob >= 0) && (ob < DIM * WPA * S) && ((ob % S) == 0);
        c_hit    = (oc >= 0) && (oc < DIM * WPC * S) && ((oc % S) == 0);
        a_row    = (oa / S) / WPA;
        a_wd     = (oa / S) % WPA;
        b_row    = (ob / S) / WPA;
        b_wd     = (ob / S) % WPA;
        c_row    = (oc / S) / WPC;
        c_wd     = (oc / S) % WPC;
        ctrl_hit = (ua == CTRL_A);
        stat_hit = (ua == STAT_A);
        cyc_hit  = (ua == CYC_A);
    end

    // Read mux. C is hidden while the engine is rewriting it.
    always_comb begin
        dataOut = '0;
        if (a_hit) begin
            for (int j = 0; j < EPA; j++)
                if (a_wd * EPA + j < DIM)
                    dataOut[j*BITS_AB +: BITS_AB] = a_q[IW'(a_row)][IW'(a_wd * EPA + j)];
        end else if (b_hit) begin
            for (int j = 0; j < EPA; j++)
                if (b_wd * EPA + j < DIM)
                    dataOut[j*BITS_AB +: BITS_AB] = b_q[IW'(b_row)][IW'(b_wd * EPA + j)];
        end else if (c_hit && !busy_q) begin
            for (int j = 0; j < EPC; j++)
                if (c_wd * EPC + j < DIM)
                    dataOut[j*BITS_C +: BITS_C] = c_q[IW'(c_row)][IW'(c_wd * EPC + j)];
        end else if (stat_hit) begin
            dataOut[1:0] = {sticky_q, busy_q};
        end else if (cyc_hit) begin
            dataOut[CW-1:0] = cycles_q;
        end
    end

    // Next-state: host writes in IDLE, MAC sweep in RUN.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        state_d  = state_q;
        i_d      = i_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        case (state_q)
            IDLE: begin
                if (r_w) begin
                    if (a_hit)
                        for (int j = 0; j < EPA; j++)
                            if (a_wd * EPA + j < DIM)
                                a_d[IW'(a_row)][IW'(a_wd * EPA + j)] = dataIn[j*BITS_AB +: BITS_AB];
                    if (b_hit)
                        for (int j = 0; j < EPA; j++)
                            if (b_wd * EPA + j < DIM)
                                b_d[IW'(b_row)][IW'(b_wd * EPA + j)] = dataIn[j*BITS_AB +: BITS_AB];
                    if (c_hit)
                        for (int j = 0; j < EPC; j++)
                            if (c_wd * EPC + j < DIM)
                                c_d[IW'(c_row)][IW'(c_wd * EPC + j)] = dataIn[j*BITS_C +: BITS_C];
                    if (ctrl_hit) begin
                        state_d  = RUN;
                        i_d      = '0;
                        k_d      = '0;
                        cnt_d    = '0;
                        sticky_d = 1'b0;
                        acc_d    = dataIn[0];
                    end
                end
            end
            RUN: begin
                // k = 0 starts a fresh dot product unless accumulating into C.
                for (int j = 0; j < DIM; j++)
                    c_d[i_q][IW'(j)] = mac_step((k_q != '0 || acc_q) ? c_q[i_q][IW'(j)] : '0,
                                                a_q[i_q][k_q], b_q[k_q][IW'(j)]);
                cnt_d = cnt_q + 1'b1;
                if (k_q == LAST) begin
                    k_d = '0;
                    if (i_q == LAST) begin
                        state_d  = IDLE;
                        sticky_d = 1'b1;
                        cycles_d = cnt_q + 1'b1;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered: look ahead at the state being entered.
        busy_d = (state_d == RUN);
        done_d = (state_d == RUN) && (i_d == LAST) && (k_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '{default: '0};
            b_q      <= '{default: '0};
            c_q      <= '{default: '0};
            state_q  <= IDLE;
            i_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            acc_q    <= 1'b0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            state_q  <= state_d;
            i_q      <= i_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_tpuv2.sv
// Testbench for tpuv2 (default parameters: 8-bit A/B, 16-bit C, DIM 8, 64-bit MMIO).
// Stimulus pushes expected read values and expected run lengths into queues;
// a negedge monitor pops and compares them against what the DUT presents.
module tb_tpuv2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] addr = '0;
    logic [63:0] dataIn = '0;
    logic [63:0] dataOut;
    logic        busy, done;

    tpuv2 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .r_w     (r_w),
        .addr    (addr),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

`ifdef SATURATE_EN
    localparam logic [63:0] OVF_WORD = {4{16'h7FFF}};
`else
    localparam logic [63:0] OVF_WORD = {4{16'h0000}};
`endif
    localparam logic [63:0] ONES8 = 64'h0101_0101_0101_0101;
    localparam logic [63:0] NEG8  = 64'h8080_8080_8080_8080;
    localparam logic [63:0] ALLF  = 64'hFFFF_FFFF_FFFF_FFFF;

    // Scoreboard state
    logic        rd_req = 1'b0;
    logic        rd_sel = 1'b0;
    logic        tmo = 1'b0;
    logic        fin = 1'b0;
    logic [63:0] exp_q [$];
    string       name_q [$];
    int          run_q [$];
    int          checks = 0;
    int          errors = 0;
    int          busy_run = 0;
    int          done_run = 0;

    always @(negedge clk) begin
        logic [63:0] e, act;
        string       n;
        int          er;
        if (rd_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: read presented with no expected value queued");
            end else begin
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                act = rd_sel ? {62'b0, done, busy} : dataOut;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, act, e);
                end
            end
        end
        if (!rst_n) begin
            busy_run = 0;
            done_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) done_run++;
            if (!busy && busy_run != 0) begin
                checks += 2;
                er = (run_q.size() != 0) ? run_q.pop_front() : -1;
                if (busy_run != er) begin
                    errors++;
                    $display("FAIL run_length: got %0d busy cycles expected %0d", busy_run, er);
                end
                if (done_run != 1) begin
                    errors++;
                    $display("FAIL done_pulses: got %0d expected 1", done_run);
                end
                busy_run = 0;
                done_run = 0;
            end
        end
        if (tmo) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: busy still %b after 200 cycles expected 0", busy);
        end
        if (fin) begin
            checks++;
            if (exp_q.size() != 0 || run_q.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d reads %0d runs pending expected 0 0",
                         exp_q.size(), run_q.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        r_w = 1'b1; addr = a; dataIn = d;
        tick();
        r_w = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [63:0] e, input string n);
        r_w = 1'b0; addr = a; rd_sel = 1'b0; rd_req = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(n);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic probe(input logic [1:0] e, input string n);
        rd_sel = 1'b1; rd_req = 1'b1;
        exp_q.push_back({62'b0, e});
        name_q.push_back(n);
        tick();
        rd_req = 1'b0; rd_sel = 1'b0;
    endtask

    task automatic start(input logic acc);
        run_q.push_back(64);
        wr(16'h0400, {63'b0, acc});
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        tick();
        if (!seen) begin
            tmo = 1'b1;
            tick();
            tmo = 1'b0;
        end
    endtask

    // B[r][c] = r*8 + c - 32, packed as bytes
    function automatic logic [63:0] brow(input int r);
        logic [63:0] w;
        w = '0;
        for (int c = 0; c < 8; c++) w[c*8 +: 8] = 8'(r * 8 + c - 32);
        return w;
    endfunction

    // Same values sign-extended to 16 bits; word w holds columns 4w..4w+3
    function automatic logic [63:0] crow(input int r, input int w);
        logic [63:0] x;
        x = '0;
        for (int j = 0; j < 4; j++) x[j*16 +: 16] = 16'(r * 8 + 4 * w + j - 32);
        return x;
    endfunction

    function automatic logic [63:0] irow(input int r);
        return 64'h1 << (8 * r);
    endfunction

    task automatic load_identity_pattern();
        for (int r = 0; r < 8; r++) wr(16'(32'h100 + r * 8), irow(r));
        for (int r = 0; r < 8; r++) wr(16'(32'h200 + r * 8), brow(r));
    endtask

    task automatic check_c_pattern(input string tag);
        for (int r = 0; r < 8; r++)
            for (int w = 0; w < 2; w++)
                rd(16'(32'h300 + r * 16 + w * 8), crow(r, w), $sformatf("%s_c_r%0d_w%0d", tag, r, w));
    endtask

    task automatic check_c_all(input logic [63:0] e, input string tag);
        for (int n = 0; n < 16; n++)
            rd(16'(32'h300 + n * 8), e, $sformatf("%s_c_word%0d", tag, n));
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        probe(2'b00, "reset_busy_done");
        rd(16'h0408, 64'h0, "reset_status");
        rd(16'h0410, 64'h0, "reset_cycles");
        rd(16'h0300, 64'h0, "reset_c0");
        rd(16'h0100, 64'h0, "reset_a0");

        // 1. Identity: C = B sign-extended
        load_identity_pattern();
        rd(16'h0110, irow(2), "a_row2_readback");
        rd(16'h0218, brow(3), "b_row3_readback");
        start(1'b0);
        probe(2'b01, "busy_after_start");
        wait_idle();
        check_c_pattern("ident");
        rd(16'h0408, 64'h2, "ident_status");
        rd(16'h0410, 64'd64, "ident_cycles");

        // 2. Accumulate onto preloaded C, then overwrite
        for (int n = 0; n < 16; n++) wr(16'(32'h300 + n * 8), {4{16'h0005}});
        rd(16'h0308, {4{16'h0005}}, "c_preload");
        for (int r = 0; r < 8; r++) begin
            wr(16'(32'h100 + r * 8), ONES8);
            wr(16'(32'h200 + r * 8), ONES8);
        end
        start(1'b1);
        wait_idle();
        check_c_all({4{16'h000D}}, "acc1");
        start(1'b0);
        wait_idle();
        check_c_all({4{16'h0008}}, "acc0");

        // 3. Overflow: 8 * (-128 * -128)
        for (int r = 0; r < 8; r++) begin
            wr(16'(32'h100 + r * 8), NEG8);
            wr(16'(32'h200 + r * 8), NEG8);
        end
        start(1'b0);
        wait_idle();
        check_c_all(OVF_WORD, "ovf");

        // 4. Writes, CTRL and C reads locked out while busy
        load_identity_pattern();
        start(1'b0);
        repeat (9) tick();
        wr(16'h0100, ALLF);
        wr(16'h0400, 64'h1);
        rd(16'h0300, 64'h0, "busy_c_read");
        rd(16'h0408, 64'h1, "busy_status");
        wait_idle();
        rd(16'h0100, irow(0), "lockout_a_row0");
        check_c_pattern("lockout");

        // 5. Reverse-order loads and unmapped addresses
        for (int r = 0; r < 8; r++) begin
            wr(16'(32'h100 + r * 8), 64'h0);
            wr(16'(32'h200 + r * 8), 64'h0);
        end
        for (int r = 7; r >= 0; r--) wr(16'(32'h200 + r * 8), brow(r));
        for (int r = 7; r >= 0; r--) wr(16'(32'h100 + r * 8), irow(r));
        wr(16'h0101, ALLF);
        wr(16'h0140, ALLF);
        wr(16'h0500, ALLF);
        wr(16'h0408, ALLF);
        wr(16'h0410, ALLF);
        rd(16'h0101, 64'h0, "unmapped_0101");
        rd(16'h0140, 64'h0, "unmapped_0140");
        rd(16'h0500, 64'h0, "unmapped_0500");
        rd(16'h0410, 64'd64, "cycles_write_ignored");
        rd(16'h0100, irow(0), "a_row0_after_unmapped");
        start(1'b0);
        wait_idle();
        check_c_pattern("reverse");

        // 6. Reset in the middle of a run
        wr(16'h0400, 64'h0);
        repeat (29) tick();
        rst_n = 1'b0;
        probe(2'b00, "busy_in_reset");
        tick();
        rst_n = 1'b1;
        tick();
        rd(16'h0100, 64'h0, "rst_a0");
        rd(16'h0238, 64'h0, "rst_b7");
        rd(16'h0300, 64'h0, "rst_c0");
        rd(16'h0378, 64'h0, "rst_c15");
        rd(16'h0408, 64'h0, "rst_status");
        rd(16'h0410, 64'h0, "rst_cycles");
        probe(2'b00, "rst_idle");

        fin = 1'b1;
        tick();
        fin = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpuv2.md
Name: tpuv2

Overview:
Parametrised successor to the v1 matrix-multiply accelerator behind the CCI-P MMIO shim; computes C = A*B or C = C + A*B on DIM x DIM signed matrices. The host uses a single-word MMIO interface (r_w, addr, dataIn, dataOut), extended with randomly addressable row words, a status register and a cycle counter. Compute runs on a DIM-lane output-stationary MAC engine with deterministic latency, and the block contains all of its own storage.

Parameters:
- BITS_AB, 8: signed A/B element width.
- BITS_C, 16: signed C element and accumulator width.
- DIM, 8: matrix dimension.
- ADDRW, 16: MMIO address width.
- DATAW, 64: MMIO data width. Must be a multiple of BITS_C and of BITS_AB.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- r_w, input, 1: 0 = read, 1 = write. A write is one cycle with r_w=1.
- addr, input, ADDRW: byte address.
- dataIn, input, DATAW: write data.
- dataOut, output, DATAW: read data, combinational from addr.
- busy, output, 1: high while the engine runs.
- done, output, 1: one-cycle pulse on the last compute cycle.

Behaviour:
- Derived constants:
  - S = DATAW/8 (bytes per word).
  - EPA = DATAW/BITS_AB; WPA = ceil(DIM/EPA).
  - EPC = DATAW/BITS_C; WPC = ceil(DIM/EPC).
- Address map, with word offset n = (addr - base)/S:
  - A at 0x0100: row = n/WPA, w = n%WPA.
  - B at 0x0200: same indexing as A.
  - C at 0x0300: row = n/WPC, w = n%WPC.
  - CTRL at 0x0400.
  - STATUS at 0x0400+S.
  - CYCLES at 0x0400+2S.
  - A non-multiple-of-S offset or a row >= DIM decodes to nothing.
- Packing: word w of a row holds element w*EPx+j at dataIn[j*BITS +: BITS]. Element indices >= DIM are ignored on write and read back as 0.
- Writes, when not busy:
  - A/B/C word writes update the addressed elements on the clock edge. Any order is allowed; no sequencing counters.
  - CTRL write starts a run. dataIn[0] = ACC: 1 accumulates into C, 0 overwrites C.
  - Writes to STATUS, CYCLES or unmapped addresses are ignored.
- Writes while busy, including to CTRL, are ignored.
- Reads:
  - A/B/C return the packed word.
  - STATUS returns {.., done_sticky (bit1), busy (bit0)}.
  - CYCLES returns the cycle count of the last completed run, zero-extended.
  - Unmapped addresses return 0.
  - C reads while busy return 0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on a CTRL write. Row counter i = 0, k counter = 0, cycle counter cleared, done_sticky cleared, ACC latched.
  - In RUN, each cycle for all lanes j in parallel: C[i][j] <= base + A[i][k]*B[k][j], where base = C[i][j] if (k>0 or ACC), else 0.
  - k increments each cycle; at k=DIM-1, k wraps to 0 and i increments.
  - RUN -> IDLE after the cycle with i=DIM-1 and k=DIM-1. done pulses in that cycle; done_sticky sets and the cycle count is captured on that edge.
- Timing: busy is high for exactly DIM*DIM cycles, starting the cycle after the CTRL write edge. CYCLES reads DIM*DIM after every run.
- Arithmetic:
  - Product is a full 2*BITS_AB signed value, sign-extended or truncated to BITS_C.
  - Sum wraps modulo 2^BITS_C (two's complement) unless SATURATE_EN is defined.
- Reset (async, any time, including mid-run):
  - Outputs: busy=0, done=0; dataOut reflects the cleared state.
  - Cleared to 0: A, B, C storage, all counters, done_sticky and CYCLES.
  - State returns to IDLE; an in-flight run is discarded.

Optional Feature:
SATURATE_EN
- Defined: each accumulate step clamps to [-2^(BITS_C-1), 2^(BITS_C-1)-1] before being stored.
- Undefined: wraparound as above.
- Both builds behave identically when no step overflows.

Test Plan:
1. Identity check: write A = I (element 1 on the diagonal) and B[r][c] = r*8+c-32, start with ACC=0. Required: busy high 64 cycles, done pulse once, then each C row equals the matching B row sign-extended to 16 bits. STATUS reads 0x2 and CYCLES reads 64.
2. Accumulate: preload C = all 0x0005, A = B = all 1, start with ACC=1. Required: every C element = 0x000D (5+8). Repeat with ACC=0: every C element = 0x0008.
3. Overflow: A = B = all -128 (0x80). Without the macro, C = 8*16384 mod 2^16 = 0x0000. With SATURATE_EN, C = 0x7FFF.
4. Busy lockout: start a run, then at cycle 10 write A row 0 = 0xFF.., CTRL again, and read C. Required: writes ignored, C read returns 0, run finishes at 64 cycles with the original result.
5. Random order: write A/B words in reverse address order and hit unmapped addresses (0x0101, 0x0140, 0x0500). Required: results match the in-order case, and unmapped reads return 0.
6. Reset mid-run: assert rst_n=0 at RUN cycle 30. Required: busy=0 immediately; all A/B/C reads, STATUS and CYCLES read 0 after release.
